ce_pilot_sequencer: RTL and testbench

- Controls the pilot-aided channel-estimation/equalization datapath: per-frame sequencer deciding, for each accepted sample, whether it is a pilot (weight-update) sample and which stored weight bank it uses/updates.
- Issues the weight re-initialisation pulse at frame start.
- Runs the valid/ready handshake around a fixed-latency datapath and signals frame completion.
- Sits between the sample source and the CE datapath; the datapath consumes ce_en/ce_pilot/ce_bank/ce_weight_init.

---
 rtl/ce_seq_pkg.sv | 30 +++
 rtl/ce_seq_pipe_tracker.sv | 42 ++++
 rtl/ce_pilot_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_ce_pilot_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ce_seq_pkg.sv
// Shared types and constants for the pilot-aided channel-estimation sequencer.
// Holds the sequencer state encoding, datapath word widths and the Q2.32 unity weight.
package ce_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_TRAIN = 3'd2,
    ST_TRACK = 3'd3,
    ST_DRAIN = 3'd4
  } ce_seq_state_t;

  // Datapath word formats: sample width, weight width, weight fraction bits.
  localparam int W_SIG = 40;
  localparam int W_WGT = 34;
  localparam int FRAC  = 32;

  // Weight value the datapath loads into every bank on ce_weight_init.
  localparam logic [W_WGT-1:0] ONE_Q32 = 34'h1_0000_0000;

  // Bank index width; never narrower than one bit.
  function automatic int BANK_W(input int num_banks);
    if (num_banks <= 2) begin
      return 1;
    end else begin
      return $clog2(num_banks);
    end
  endfunction

endpackage

// File: rtl/ce_seq_pipe_tracker.sv
// Valid/last shadow of the fixed-latency CE datapath.
// Each stage advances only when the datapath advances, so the tags stay
// aligned with the samples travelling through the datapath registers.
module ce_seq_pipe_tracker #(
  parameter int PIPE_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic adv,
  input  logic in_valid,
  input  logic in_last,
  output logic m_valid,
  output logic m_last,
  output logic empty
);

  logic [PIPE_LAT-1:0] valid_r;
  logic [PIPE_LAT-1:0] last_r;

  // Shift the valid/last tags one stage on every datapath advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= {PIPE_LAT{1'b0}};
      last_r  <= {PIPE_LAT{1'b0}};
    end else if (adv) begin
      valid_r[0] <= in_valid;
      last_r[0]  <= in_valid & in_last;
      for (int i = 1; i < PIPE_LAT; i++) begin
        valid_r[i] <= valid_r[i-1];
        last_r[i]  <= last_r[i-1];
      end
    end else begin
      valid_r <= valid_r;
      last_r  <= last_r;
    end
  end

  assign m_valid = valid_r[PIPE_LAT-1];
  assign m_last  = valid_r[PIPE_LAT-1] & last_r[PIPE_LAT-1];
  assign empty   = ~(|valid_r);

endmodule

// File: rtl/ce_pilot_sequencer.sv
// Per-frame sequencer for the pilot-aided channel-estimation datapath.
// Marks each accepted sample as pilot or data, picks its weight bank, pulses
// the weight re-initialisation at frame start and runs the handshake around
// the fixed-latency datapath until the frame has drained.
// Optional build macro CE_SEQ_STATS_EN adds per-frame pilot/stall counters.
module ce_pilot_sequencer
  import ce_seq_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int CNT_W     = 16,
  parameter int PIPE_LAT  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [CNT_W-1:0]            cfg_frame_len,
  input  logic [CNT_W-1:0]            cfg_train_len,
  input  logic [CNT_W-1:0]            cfg_pilot_period,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last,
  output logic                        ce_en,
  output logic                        ce_pilot,
  output logic [BANK_W(NUM_BANKS)-1:0] ce_bank,
  output logic                        ce_weight_init,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        cfg_err
`ifdef CE_SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0]            stat_pilots,
  output logic [CNT_W-1:0]            stat_stalls
`endif
);

  localparam int BW = BANK_W(NUM_BANKS);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0]    BANK_ONE = {{(BW-1){1'b0}}, 1'b1};

  ce_seq_state_t    state_r;
  ce_seq_state_t    state_nx_s;
  logic [CNT_W-1:0] frame_len_r;
  logic [CNT_W-1:0] train_len_r;
  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] k_r;
  logic [CNT_W-1:0] phase_r;
  logic [BW-1:0]    bank_r;
  logic             cfg_err_r;

  logic in_frame_s;
  logic adv_s;
  logic accept_s;
  logic phase_hit_s;
  logic pilot_s;
  logic is_last_s;
  logic pipe_empty_s;

  assign in_frame_s = (state_r == ST_TRAIN) || (state_r == ST_TRACK);
  assign adv_s      = m_ready | ~m_valid;
  assign s_ready    = in_frame_s & adv_s;
  assign accept_s   = s_valid & s_ready;
  assign is_last_s  = (k_r == (frame_len_r - CNT_ONE));

  // A period of 0 or 1 makes every tracking sample a pilot.
  assign phase_hit_s = (period_r <= CNT_ONE) || (phase_r == (period_r - CNT_ONE));
  assign pilot_s     = (state_r == ST_TRAIN) || ((state_r == ST_TRACK) && phase_hit_s);

  // Pilot flag and bank are presented alongside the sample being offered.
  assign ce_pilot = s_valid & in_frame_s & pilot_s;
  assign ce_bank  = (s_valid && in_frame_s) ? bank_r : {BW{1'b0}};
  assign cfg_err  = cfg_err_r;

  ce_seq_pipe_tracker #(
    .PIPE_LAT (PIPE_LAT)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .adv      (adv_s),
    .in_valid (accept_s),
    .in_last  (is_last_s),
    .m_valid  (m_valid),
    .m_last   (m_last),
    .empty    (pipe_empty_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode and control outputs; ce_en stays low in IDLE where the pipe is empty.
  always_comb begin
    state_nx_s     = state_r;
    ce_en          = 1'b0;
    ce_weight_init = 1'b0;
    busy           = 1'b0;
    frame_done     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && (cfg_frame_len != CNT_ZERO)) begin
          state_nx_s = ST_INIT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_INIT: begin
        busy           = 1'b1;
        ce_en          = adv_s;
        ce_weight_init = 1'b1;
        if (train_len_r != CNT_ZERO) begin
          state_nx_s = ST_TRAIN;
        end else begin
          state_nx_s = ST_TRACK;
        end
      end
      ST_TRAIN: begin
        busy  = 1'b1;
        ce_en = adv_s;
        if (accept_s && is_last_s) begin
          state_nx_s = ST_DRAIN;
        end else if (accept_s && (k_r == (train_len_r - CNT_ONE))) begin
          state_nx_s = ST_TRACK;
        end else begin
          state_nx_s = ST_TRAIN;
        end
      end
      ST_TRACK: begin
        busy  = 1'b1;
        ce_en = adv_s;
        if (accept_s && is_last_s) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_TRACK;
        end
      end
      ST_DRAIN: begin
        busy  = 1'b1;
        ce_en = adv_s;
        if (pipe_empty_s) begin
          frame_done = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Frame configuration latch plus sample, phase and bank counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_len_r <= CNT_ZERO;
      train_len_r <= CNT_ZERO;
      period_r    <= CNT_ZERO;
      k_r         <= CNT_ZERO;
      phase_r     <= CNT_ZERO;
      bank_r      <= {BW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && (cfg_frame_len != CNT_ZERO)) begin
            frame_len_r <= cfg_frame_len;
            train_len_r <= cfg_train_len;
            period_r    <= cfg_pilot_period;
          end
        end
        ST_INIT: begin
          k_r     <= CNT_ZERO;
          phase_r <= CNT_ZERO;
          bank_r  <= {BW{1'b0}};
        end
        ST_TRAIN, ST_TRACK: begin
          if (accept_s) begin
            k_r <= k_r + CNT_ONE;
            if (pilot_s) begin
              bank_r <= bank_r + BANK_ONE;
            end
            if (state_r == ST_TRACK) begin
              phase_r <= phase_hit_s ? CNT_ZERO : (phase_r + CNT_ONE);
            end
          end
        end
        default: begin
          k_r <= k_r;
        end
      endcase
    end
  end

  // Rejected start (zero-length frame while idle) gives a one-cycle error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= (state_r == ST_IDLE) && start && (cfg_frame_len == CNT_ZERO);
    end
  end

`ifdef CE_SEQ_STATS_EN
  logic [CNT_W-1:0] stat_pilots_r;
  logic [CNT_W-1:0] stat_stalls_r;

  // Saturating per-frame counts of accepted pilots and upstream stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_pilots_r <= CNT_ZERO;
      stat_stalls_r <= CNT_ZERO;
    end else if (state_r == ST_INIT) begin
      stat_pilots_r <= CNT_ZERO;
      stat_stalls_r <= CNT_ZERO;
    end else begin
      if (accept_s && pilot_s && (stat_pilots_r != {CNT_W{1'b1}})) begin
        stat_pilots_r <= stat_pilots_r + CNT_ONE;
      end
      if (in_frame_s && s_valid && !s_ready && (stat_stalls_r != {CNT_W{1'b1}})) begin
        stat_stalls_r <= stat_stalls_r + CNT_ONE;
      end
    end
  end

  assign stat_pilots = stat_pilots_r;
  assign stat_stalls = stat_stalls_r;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ce_pilot_sequencer.sv
// Self-checking bench for ce_pilot_sequencer: a per-cycle vector table for two
// complete frames and a rejected start, plus hand-written multi-cycle sequences
// for back-pressure, start-while-busy and mid-frame reset.
module tb_ce_pilot_sequencer;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] cfg_frame_len;
  logic [CNT_W-1:0] cfg_train_len;
  logic [CNT_W-1:0] cfg_pilot_period;
  logic             s_valid;
  logic             s_ready;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic             ce_en;
  logic             ce_pilot;
  logic [0:0]       ce_bank;
  logic             ce_weight_init;
  logic             busy;
  logic             frame_done;
  logic             cfg_err;
`ifdef CE_SEQ_STATS_EN
  logic [CNT_W-1:0] stat_pilots;
  logic [CNT_W-1:0] stat_stalls;
`endif

  ce_pilot_sequencer #(.NUM_BANKS(2), .CNT_W(CNT_W), .PIPE_LAT(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .cfg_frame_len    (cfg_frame_len),
    .cfg_train_len    (cfg_train_len),
    .cfg_pilot_period (cfg_pilot_period),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_last           (m_last),
    .ce_en            (ce_en),
    .ce_pilot         (ce_pilot),
    .ce_bank          (ce_bank),
    .ce_weight_init   (ce_weight_init),
    .busy             (busy),
    .frame_done       (frame_done),
    .cfg_err          (cfg_err)
`ifdef CE_SEQ_STATS_EN
    ,
    .stat_pilots      (stat_pilots),
    .stat_stalls      (stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  // Output word order: s_ready m_valid m_last ce_en ce_pilot ce_bank ce_weight_init busy frame_done cfg_err
  typedef struct {
    logic             start;
    logic             s_valid;
    logic             m_ready;
    logic [CNT_W-1:0] flen;
    logic [CNT_W-1:0] tlen;
    logic [CNT_W-1:0] per;
    logic [9:0]       exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  logic [CNT_W-1:0] cur_flen, cur_tlen, cur_per;

  function automatic logic [9:0] out_word();
    return {s_ready, m_valid, m_last, ce_en, ce_pilot, ce_bank[0],
            ce_weight_init, busy, frame_done, cfg_err};
  endfunction

  task automatic add_vec(input logic st, input logic sv, input logic mr, input logic [9:0] exp);
    vec_t v;
    v.start = st; v.s_valid = sv; v.m_ready = mr;
    v.flen = cur_flen; v.tlen = cur_tlen; v.per = cur_per; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Full frame of 8 with optional back-pressure; a zero-length start is issued while busy.
  task automatic run_frame(input int stall_len);
    int acc = 0, outs = 0, last_at = 0, lasts = 0, stalls = 0, bad = 0, errs = 0;
    logic done_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; cfg_frame_len = 16'd8; cfg_train_len = 16'd0; cfg_pilot_period = 16'd2;
    s_valid = 1'b1; m_ready = 1'b1;
    for (int cyc = 1; cyc < 60 && !done_seen; cyc++) begin
      @(negedge clk);
      start = (cyc == 5);
      cfg_frame_len = (cyc == 5) ? 16'd0 : 16'd8;
      m_ready = !((cyc >= 6) && (cyc < 6 + stall_len));
      #1;
      if (s_valid && s_ready) acc++;
      if (m_valid && m_ready) begin
        outs++;
        if (m_last) begin lasts++; last_at = outs; end
      end
      if (m_valid && !m_ready) begin
        stalls++;
        if (s_ready || ce_en) bad++;
      end
      if (cfg_err) errs++;
      if (frame_done) done_seen = 1'b1;
    end
    chk("frame_done_seen", int'(done_seen), 1);
    chk("accepts", acc, 8);
    chk("outputs", outs, 8);
    chk("m_last_count", lasts, 1);
    chk("m_last_position", last_at, 8);
    chk("stall_cycles", stalls, stall_len);
    chk("ready_or_en_during_stall", bad, 0);
    chk("cfg_err_while_busy", errs, 0);
    @(negedge clk);
    start = 1'b0; cfg_frame_len = 16'd8;
    #1;
    chk("idle_after_frame", int'(busy), 0);
`ifdef CE_SEQ_STATS_EN
    chk("stat_pilots", int'(stat_pilots), 4);
    chk("stat_stalls", int'(stat_stalls), stall_len);
`endif
  endtask

  // Synchronous reset after four accepted samples of an 8-sample frame.
  task automatic reset_mid_frame();
    int acc = 0, spur = 0;
    @(negedge clk);
    start = 1'b1; cfg_frame_len = 16'd8; cfg_train_len = 16'd0; cfg_pilot_period = 16'd2;
    s_valid = 1'b1; m_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && acc < 4; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (s_valid && s_ready) acc++;
    end
    chk("accepts_before_reset", acc, 4);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_s_ready", int'(s_ready), 0);
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (frame_done || ce_weight_init || m_valid) spur++;
      @(negedge clk);
      #1;
    end
    chk("rst_no_done_or_init", spur, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
    cfg_frame_len = 16'd0; cfg_train_len = 16'd0; cfg_pilot_period = 16'd0;

    // Frame A: len 8, no training, period 2. Pilots at k=1,3,5,7 on banks 0,1,0,1.
    cur_flen = 16'd8; cur_tlen = 16'd0; cur_per = 16'd2;
    add_vec(1'b1, 1'b1, 1'b1, 10'b0000000000); // IDLE, start seen
    add_vec(1'b0, 1'b1, 1'b1, 10'b0001001100); // INIT
    add_vec(1'b0, 1'b1, 1'b1, 10'b1001000100); // k0
    add_vec(1'b0, 1'b1, 1'b1, 10'b1001100100); // k1 pilot b0
    add_vec(1'b0, 1'b1, 1'b1, 10'b1101010100); // k2 b1, out0
    add_vec(1'b0, 1'b1, 1'b1, 10'b1101110100); // k3 pilot b1
    add_vec(1'b0, 1'b1, 1'b1, 10'b1101000100); // k4 b0
    add_vec(1'b0, 1'b1, 1'b1, 10'b1101100100); // k5 pilot b0
    add_vec(1'b0, 1'b1, 1'b1, 10'b1101010100); // k6 b1
    add_vec(1'b0, 1'b1, 1'b1, 10'b1101110100); // k7 pilot b1, last accept
    add_vec(1'b0, 1'b1, 1'b1, 10'b0101000100); // DRAIN out6
    add_vec(1'b0, 1'b1, 1'b1, 10'b0111000100); // DRAIN out7 m_last
    add_vec(1'b1, 1'b1, 1'b1, 10'b0001000110); // frame_done, start ignored
    // Frame B: len 6, train 3, period 3. Pilots k=0,1,2,5 on banks 0,1,0,1.
    cur_flen = 16'd6; cur_tlen = 16'd3; cur_per = 16'd3;
    add_vec(1'b1, 1'b1, 1'b1, 10'b0000000000); // IDLE, start seen
    add_vec(1'b0, 1'b1, 1'b1, 10'b0001001100); // INIT
    add_vec(1'b0, 1'b1, 1'b1, 10'b1001100100); // k0 train b0
    add_vec(1'b0, 1'b1, 1'b1, 10'b1001110100); // k1 train b1
    add_vec(1'b0, 1'b1, 1'b1, 10'b1101100100); // k2 train b0
    add_vec(1'b0, 1'b1, 1'b1, 10'b1101010100); // k3 track ph0 b1
    add_vec(1'b0, 1'b1, 1'b1, 10'b1101010100); // k4 track ph1 b1
    add_vec(1'b0, 1'b1, 1'b1, 10'b1101110100); // k5 pilot b1, last accept
    add_vec(1'b0, 1'b1, 1'b1, 10'b0101000100); // DRAIN out4
    add_vec(1'b0, 1'b1, 1'b1, 10'b0111000100); // DRAIN out5 m_last
    add_vec(1'b0, 1'b1, 1'b1, 10'b0001000110); // frame_done
    // Zero-length start: rejected with a registered cfg_err pulse, stays idle.
    cur_flen = 16'd0;
    add_vec(1'b1, 1'b1, 1'b1, 10'b0000000000);
    add_vec(1'b0, 1'b1, 1'b1, 10'b0000000001);
    add_vec(1'b0, 1'b1, 1'b1, 10'b0000000000);

    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", int'(out_word()), 0);
    chk("reset_m_last", int'(m_last), 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      start = vecs[i].start; s_valid = vecs[i].s_valid; m_ready = vecs[i].m_ready;
      cfg_frame_len = vecs[i].flen; cfg_train_len = vecs[i].tlen; cfg_pilot_period = vecs[i].per;
      #1;
      n_vec++;
      if (out_word() !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL vec%0d: got %b, expected %b (sr mv ml en pil bk wi bz dn ce)",
                 i, out_word(), vecs[i].exp);
      end
    end

    run_frame(4);
    reset_mid_frame();
    run_frame(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
